// File: rtl/stream_copy.sv
// stream_copy: memory-to-memory copy / fill engine.
//
// A CPU programs source, destination, word count, mode and fill value through
// a small register slave, then writes register 0 to start. In COPY mode the
// engine reads words from src and writes them to dst through a DEPTH-entry
// FIFO; in FILL mode it writes the fill value to every destination word.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   slave_*               CPU register port (never stalls, readdata is
//                         combinational from the registers)
//     0 W=start / R={done,busy}   1 dst   2 src   3 count
//     4 mode (bit0: 0=copy 1=fill) 5 fill value   6 R=words written
//   master_*              memory master with waitrequest and pipelined,
//                         in-order read returns (readdatavalid)
//
// States
//   IDLE | waiting for start, master outputs forced to 0
//   COPY | read src words into FIFO, write FIFO head to dst
//   FILL | write fill value to dst words back-to-back

module stream_copy #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          slave_waitrequest,
  input  logic [3:0]    slave_address,
  input  logic          slave_read,
  input  logic          slave_write,
  input  logic [DW-1:0] slave_writedata,
  output logic [DW-1:0] slave_readdata,
  input  logic          master_waitrequest,
  output logic [AW-1:0] master_address,
  output logic          master_read,
  output logic          master_write,
  output logic [DW-1:0] master_writedata,
  input  logic [DW-1:0] master_readdata,
  input  logic          master_readdatavalid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] STEP  = AW'(DW / 8);
  localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, COPY, FILL} state_t;

  state_t        state_q, state_n;

  logic [DW-1:0] dst_q, src_q, count_q, fill_q;
  logic          mode_q;
  logic          done_q, done_n;
  logic [DW-1:0] ww_q, ww_n;            // words written
  logic [DW-1:0] rd_iss_q, rd_iss_n;    // reads accepted by the memory
  logic [CW-1:0] in_fl_q, in_fl_n;      // reads accepted, data not yet back
  logic [CW-1:0] fcnt_q, fcnt_n;        // FIFO occupancy
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW-1:0] rd_addr_q, rd_addr_n;
  logic [AW-1:0] wr_addr_q, wr_addr_n;

  logic          master_read_q, rd_n;
  logic          master_write_q, wr_n;
  logic [AW-1:0] master_address_q, addr_n;

  logic [DW-1:0] fifo_mem [DEPTH];

  logic          busy, cfg_we, start;
  logic          rd_ack, wr_ack, stalled;
  logic          push, pop;

  assign busy    = (state_q != IDLE);
  assign cfg_we  = slave_write && !busy;
  assign start   = cfg_we && (slave_address == 4'd0);
  assign rd_ack  = master_read_q  && !master_waitrequest;
  assign wr_ack  = master_write_q && !master_waitrequest;
  assign stalled = (master_read_q || master_write_q) && master_waitrequest;

  assign slave_waitrequest = 1'b0;
  assign master_read       = master_read_q;
  assign master_write      = master_write_q;
  assign master_address    = master_address_q;
  // FIFO head only changes on a completed write, so data stays stable under stall.
  assign master_writedata  = !master_write_q    ? '0     :
                             (state_q == FILL)  ? fill_q : fifo_mem[rd_ptr_q];

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = {{(DW-2){1'b0}}, done_q, busy};
        4'd1:    slave_readdata = dst_q;
        4'd2:    slave_readdata = src_q;
        4'd3:    slave_readdata = count_q;
        4'd4:    slave_readdata = {{(DW-1){1'b0}}, mode_q};
        4'd5:    slave_readdata = fill_q;
        4'd6:    slave_readdata = ww_q;
        default: slave_readdata = '0;
      endcase
    end
  end

  // Master strobes/address are registered: the next request is chosen from
  // the counter values as they will be after this edge's completions.
  always_comb begin
    state_n   = state_q;
    done_n    = done_q;
    rd_n      = 1'b0;
    wr_n      = 1'b0;
    addr_n    = '0;
    ww_n      = ww_q;
    rd_iss_n  = rd_iss_q;
    in_fl_n   = in_fl_q;
    fcnt_n    = fcnt_q;
    rd_addr_n = rd_addr_q;
    wr_addr_n = wr_addr_q;
    push      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count_q == '0) begin
            done_n = 1'b1;
          end else begin
            done_n    = 1'b0;
            ww_n      = '0;
            rd_iss_n  = '0;
            in_fl_n   = '0;
            fcnt_n    = '0;
            rd_addr_n = AW'(src_q);
            wr_addr_n = AW'(dst_q);
            if (mode_q) begin
              state_n = FILL;
              wr_n    = 1'b1;
              addr_n  = AW'(dst_q);
            end else begin
              state_n = COPY;
              rd_n    = 1'b1;
              addr_n  = AW'(src_q);
            end
          end
        end
      end
      COPY: begin
        push     = master_readdatavalid;
        pop      = wr_ack;
        fcnt_n   = fcnt_q + CW'(push) - CW'(pop);
        in_fl_n  = in_fl_q + CW'(rd_ack) - CW'(push);
        rd_iss_n = rd_iss_q + DW'(rd_ack);
        ww_n     = ww_q + DW'(wr_ack);
        if (rd_ack) rd_addr_n = rd_addr_q + STEP;
        if (wr_ack) wr_addr_n = wr_addr_q + STEP;
        if (stalled) begin
          rd_n   = master_read_q;
          wr_n   = master_write_q;
          addr_n = master_address_q;
        end else if (ww_n == count_q) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (fcnt_n != '0) begin
          wr_n   = 1'b1;
          addr_n = wr_addr_n;
        end else if (((CW + 1)'(in_fl_n) + (CW + 1)'(fcnt_n) < LIMIT) &&
                     (rd_iss_n < count_q)) begin
          rd_n   = 1'b1;
          addr_n = rd_addr_n;
        end
      end
      FILL: begin
        ww_n = ww_q + DW'(wr_ack);
        if (wr_ack) wr_addr_n = wr_addr_q + STEP;
        if (stalled) begin
          wr_n   = 1'b1;
          addr_n = master_address_q;
        end else if (ww_n == count_q) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          wr_n   = 1'b1;
          addr_n = wr_addr_n;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      done_q           <= 1'b0;
      dst_q            <= '0;
      src_q            <= '0;
      count_q          <= '0;
      mode_q           <= 1'b0;
      fill_q           <= '0;
      ww_q             <= '0;
      rd_iss_q         <= '0;
      in_fl_q          <= '0;
      fcnt_q           <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      rd_addr_q        <= '0;
      wr_addr_q        <= '0;
      master_read_q    <= 1'b0;
      master_write_q   <= 1'b0;
      master_address_q <= '0;
    end else begin
      state_q          <= state_n;
      done_q           <= done_n;
      ww_q             <= ww_n;
      rd_iss_q         <= rd_iss_n;
      in_fl_q          <= in_fl_n;
      fcnt_q           <= fcnt_n;
      rd_addr_q        <= rd_addr_n;
      wr_addr_q        <= wr_addr_n;
      master_read_q    <= rd_n;
      master_write_q   <= wr_n;
      master_address_q <= addr_n;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (cfg_we) begin
        case (slave_address)
          4'd1:    dst_q   <= slave_writedata;
          4'd2:    src_q   <= slave_writedata;
          4'd3:    count_q <= slave_writedata;
          4'd4:    mode_q  <= slave_writedata[0];
          4'd5:    fill_q  <= slave_writedata;
          default: ;
        endcase
      end
    end
  end

  // Storage only; emptiness is defined by the reset pointers/occupancy.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= master_readdata;
  end

endmodule

// File: tb/tb_stream_copy.sv
module tb_stream_copy;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [31:0] slave_readdata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;

  stream_copy #(.DW(32), .AW(32), .DEPTH(8)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .slave_readdata       (slave_readdata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] data; int due; } ret_t;
  typedef struct { logic [3:0] addr; logic [31:0] wdata; logic [31:0] rexp; } reg_vec_t;
  typedef struct {
    logic [31:0] src; logic [31:0] dst; logic [31:0] cnt; logic mode;
    logic [31:0] fv; int lat; int stall; bit poke; int exp_max;
  } xfer_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  ret_t        ret_q[$];

  int cyc = 0;
  int lat_cfg = 3;
  int stall_pct = 0;
  bit fill_mode = 0;
  int both_cnt, fill_rd, traffic, outst, max_outst, wr_done, first_wr, last_wr;
  bit prev_stall = 0;
  logic [65:0] snap;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    @(negedge clk);
    slave_write     = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    slave_address = a;
    slave_read    = 1'b1;
    #1;
    d = slave_readdata;
    slave_read    = 1'b0;
  endtask

  // Memory model + scoreboard/protocol monitor. Works on the falling edge:
  // picks this cycle's waitrequest/readdatavalid, then judges which requests
  // will complete on the next rising edge.
  initial begin
    logic [65:0] cur;
    wr_t w;
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
        master_readdatavalid = 1'b1;
        master_readdata      = ret_q[0].data;
        void'(ret_q.pop_front());
      end else begin
        master_readdatavalid = 1'b0;
        master_readdata      = $urandom();
      end
      master_waitrequest = (stall_pct > 0) && (int'($urandom_range(99)) < stall_pct);
      cur = {master_read, master_write, master_address, master_writedata};
      if (rst_n) begin
        if (prev_stall) chk("stall_stable", 32'(cur == snap), 32'd1);
        if (master_read && master_write) both_cnt++;
        if (master_read || master_write) traffic++;
        if (fill_mode && master_read) fill_rd++;
        if (master_read && !master_waitrequest) begin
          if (exp_rd.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_read: addr %h, no read expected", master_address);
          end else begin
            chk("rd_addr", master_address, exp_rd.pop_front());
          end
          ret_q.push_back('{mem_f(master_address), cyc + lat_cfg});
          outst++;
          if (outst > max_outst) max_outst = outst;
        end
        if (master_write && !master_waitrequest) begin
          if (exp_wr.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: addr %h data %h, no write expected",
                     master_address, master_writedata);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", master_address, w.addr);
            chk("wr_data", master_writedata, w.data);
          end
          if (!fill_mode) outst--;
          wr_done++;
          if (first_wr < 0) first_wr = cyc;
          last_wr = cyc;
        end
        prev_stall = (master_read || master_write) && master_waitrequest;
        snap = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic start_xfer(input xfer_t x);
    lat_cfg = x.lat; stall_pct = x.stall; fill_mode = x.mode;
    both_cnt = 0; fill_rd = 0; outst = 0; max_outst = 0;
    wr_done = 0; first_wr = -1; last_wr = -1;
    cpu_write(4'd1, x.dst);
    cpu_write(4'd2, x.src);
    cpu_write(4'd3, x.cnt);
    cpu_write(4'd4, {31'd0, x.mode});
    cpu_write(4'd5, x.fv);
    for (int i = 0; i < int'(x.cnt); i++) begin
      if (!x.mode) exp_rd.push_back(x.src + 32'(i) * 32'd4);
      exp_wr.push_back('{x.dst + 32'(i) * 32'd4, x.mode ? x.fv : mem_f(x.src + 32'(i) * 32'd4)});
    end
    cpu_write(4'd0, 32'd1);
  endtask

  task automatic finish_xfer(input string tag, input xfer_t x);
    logic [31:0] r;
    bit fin;
    fin = 0;
    r = '0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      cpu_read(4'd0, r);
      if (r == 32'd2) fin = 1;
      else @(negedge clk);
    end
    chk({tag, "_done"}, r, 32'd2);
    cpu_read(4'd6, r);
    chk({tag, "_words"}, r, x.cnt);
    chk({tag, "_sb_empty"}, 32'(exp_rd.size() + exp_wr.size()), 32'd0);
    chk({tag, "_rw_overlap"}, 32'(both_cnt), 32'd0);
    if (x.exp_max >= 0) chk({tag, "_max_inflight"}, 32'(max_outst), 32'(x.exp_max));
    else chk({tag, "_inflight_gt8"}, 32'(max_outst > 8), 32'd0);
    if (x.mode) chk({tag, "_fill_reads"}, 32'(fill_rd), 32'd0);
    if (x.mode && x.stall == 0)
      chk({tag, "_fill_b2b"}, 32'(last_wr - first_wr), x.cnt - 32'd1);
    chk({tag, "_idle_out"},
        32'({master_read, master_write, |master_address, |master_writedata}), 32'd0);
    if (x.poke) begin
      cpu_read(4'd1, r);
      chk({tag, "_dst_kept"}, r, x.dst);
    end
  endtask

  task automatic poke_busy();
    cpu_write(4'd1, 32'h0000_BAD0);
    cpu_write(4'd3, 32'd99);
    cpu_write(4'd5, 32'h0BAD_0BAD);
    cpu_write(4'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reg_vec_t vec [9];
    xfer_t    xf  [6];
    xfer_t    xr;
    logic [31:0] r;

    vec[0] = '{4'd1,  32'h0000_0200, 32'h0000_0200};
    vec[1] = '{4'd2,  32'h0000_0100, 32'h0000_0100};
    vec[2] = '{4'd3,  32'h0000_0004, 32'h0000_0004};
    vec[3] = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0001};
    vec[4] = '{4'd4,  32'hFFFF_FFFE, 32'h0000_0000};
    vec[5] = '{4'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vec[6] = '{4'd6,  32'h0000_0055, 32'h0000_0000};
    vec[7] = '{4'd7,  32'h1234_5678, 32'h0000_0000};
    vec[8] = '{4'd15, 32'hAAAA_5555, 32'h0000_0000};

    //         src            dst            cnt    mode  fill           lat stall poke max
    xf[0] = '{32'h0000_0100, 32'h0000_0200, 32'd4,  1'b0, 32'h0,         3,  0,    0,   -1};
    xf[1] = '{32'h0000_0400, 32'h0000_0800, 32'd16, 1'b0, 32'h0,         10, 40,   1,   -1};
    xf[2] = '{32'h0000_0000, 32'h0000_0040, 32'd5,  1'b1, 32'hDEAD_BEEF, 1,  0,    0,   -1};
    xf[3] = '{32'hFFFF_FFFC, 32'h0000_0300, 32'd2,  1'b0, 32'h0,         2,  0,    0,   -1};
    xf[4] = '{32'h0000_1000, 32'h0000_3000, 32'd12, 1'b0, 32'h0,         12, 0,    0,   8};
    xf[5] = '{32'h0000_0500, 32'h0000_0640, 32'd10, 1'b1, 32'h1234_5678, 1,  35,   0,   -1};

    rst_n = 1'b0;
    slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs",
        32'({master_read, master_write, |master_address, |master_writedata, slave_waitrequest}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_read(4'd0, r);
    chk("rst_status", r, 32'd0);
    cpu_read(4'd6, r);
    chk("rst_words", r, 32'd0);

    for (int i = 0; i < 9; i++) begin
      cpu_write(vec[i].addr, vec[i].wdata);
      cpu_read(vec[i].addr, r);
      chk($sformatf("reg_vec%0d", i), r, vec[i].rexp);
    end

    // count==0: done the next cycle, no master traffic
    traffic = 0;
    cpu_write(4'd3, 32'd0);
    cpu_write(4'd0, 32'd1);
    cpu_read(4'd0, r);
    chk("cnt0_done", r, 32'd2);
    repeat (5) @(negedge clk);
    chk("cnt0_traffic", 32'(traffic), 32'd0);

    for (int i = 0; i < 6; i++) begin
      start_xfer(xf[i]);
      if (xf[i].poke) poke_busy();
      finish_xfer($sformatf("xfer%0d", i), xf[i]);
    end

    // reset in the middle of an 8-word copy, with reads still in flight
    xr = '{32'h0000_1000, 32'h0000_2000, 32'd8, 1'b0, 32'h0, 4, 0, 0, -1};
    start_xfer(xr);
    for (int c = 0; c < 200 && wr_done < 3; c++) @(negedge clk);
    chk("rstmid_reached", 32'(wr_done >= 3), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_outputs",
        32'({master_read, master_write, |master_address, |master_writedata}), 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 50 && ret_q.size() != 0; c++) @(negedge clk);
    chk("rstmid_strays_drained", 32'(ret_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    cpu_read(4'd0, r);
    chk("rstmid_status", r, 32'd0);
    cpu_read(4'd6, r);
    chk("rstmid_words", r, 32'd0);
    cpu_read(4'd1, r);
    chk("rstmid_dst_cleared", r, 32'd0);
    chk("rstmid_idle_out",
        32'({master_read, master_write, |master_address, |master_writedata}), 32'd0);

    xr = '{32'h0000_7000, 32'h0000_9000, 32'd8, 1'b0, 32'h0, 4, 0, 0, -1};
    start_xfer(xr);
    finish_xfer("after_rst", xr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
